a_ctrls_tx: RTL and testbench
=============================

Name: a_ctrls_tx

Overview:
Control-frame transmitter, the sending end of the serial control link that the effects chain decodes into tone, delay and gain values. Watches seven 8-bit control values and, on any change or on request, serialises an ASCII frame for that channel over an 8N1 UART line. Used on the panel/controller side, or as loopback stimulus for the receiving side.

Parameters:
fCLK, 50_000_000, system clock frequency in Hz
fBAUD, 9_600, line baud rate; bit period BIT_CYC = fCLK/fBAUD clocks (integer, truncated, must be >= 2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
blend  in  8  channel 0 value
gain  in  8  channel 1 value
a8  in  8  channel 2 value
a5  in  8  channel 3 value
a4  in  8  channel 4 value
delay  in  8  channel 5 value
feedbk  in  8  channel 6 value
force_all  in  1  one-cycle pulse: queue all 7 channels for resend
CTRL_TX  out  1  serial line, idle high
busy  out  1  high while a frame is in flight
frame_done  out  1  one-cycle pulse at the end of the last stop bit of a frame

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low. While reset_n=0: CTRL_TX=1, busy=0, frame_done=0, FSM=IDLE, 7 shadow registers=0x00, force bits=0, round-robin pointer=0, baud and bit counters=0.
- Frame: ':' (0x3A), channel index as ASCII '0'..'6' (0x30+i), high nibble hex, low nibble hex, LF (0x0A). Hex digits are uppercase: 0x30-0x39, 0x41-0x46. Total 5 bytes.
- Byte encoding: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BIT_CYC clocks. No idle gap between bytes within a frame.
- Pending(i) = (input_i != shadow_i) OR force_i.
- Channel selection: in IDLE, select the first pending channel scanning from pointer upward, mod 7.
- On the selecting edge: latch input_i into the frame register, set shadow_i to the latched value, clear force_i, set pointer to (i+1) mod 7, go to START, set busy=1.
- Line timing: CTRL_TX drives the start bit from the cycle after the selecting edge. CTRL_TX is registered, with no combinational path from the inputs.
- FSM: IDLE -> START (BIT_CYC) -> DATA (8 x BIT_CYC) -> STOP (BIT_CYC).
- After STOP: go to START of the next byte if byte index < 4. Otherwise pulse frame_done, set busy=0 and return to IDLE.
- Frame spacing: IDLE always lasts at least 1 clock, so back-to-back frames are separated by exactly one idle-high clock.
- Input change during a frame: the frame carries the latched value. The new value differs from the shadow and is sent in a later frame.
- force_all behaviour: sets all force bits in one cycle. If it coincides with the selecting edge of channel i, the set wins and force_i stays 1, so channel i is sent again.
- Reset mid-frame: the line returns high immediately and the frame is abandoned. After release, every nonzero channel is pending, because the shadows are 0.

Optional Feature:
Macro: A_CTRLS_TX_CHKSUM_EN
- When defined: two uppercase hex digits of the checksum are inserted before LF, giving a 7-byte frame. Checksum = (i + value) mod 256, where i is the raw channel index 0..6.
- When undefined: frames are 5 bytes and there is no checksum logic.

Test Plan:
All scenarios use fCLK=16 and fBAUD=1, so BIT_CYC=16.
1. Reset release, all inputs 0, no force_all for 2000 clocks -> CTRL_TX constantly 1, busy=0, no frame_done.
2. gain=0x3C -> bytes 3A 31 33 43 0A. Each bit is 16 clocks, the frame is 800 clocks, busy is high throughout, and frame_done pulses once. With the macro: 3A 31 33 43 33 44 0A.
3. blend=0xA5 and feedbk=0x01 in the same cycle -> frame "0A5" then "601". Exactly 1 idle clock separates the frames.
4. All inputs 0, force_all pulse -> 7 frames for channels 0..6 in order, each with value "00", then idle.
5. gain changes 0x3C->0x3D mid-frame -> the current frame sends "3C", the next frame sends "13D", then idle.
6. delay=0x80, reset_n asserted during the 2nd byte -> CTRL_TX=1 within the same cycle. After release, a full "580" frame is sent.

Source files
------------

// File: rtl/a_ctrls_tx.sv
// a_ctrls_tx: control-frame transmitter for the effects-chain control link.
// It watches seven 8-bit control values. When one of them changes, or when
// force_all requests a resend, it sends an ASCII frame over an 8N1 UART line:
//   ':'  '0'+chan  HEX(value[7:4])  HEX(value[3:0])  LF
// Optional feature macro A_CTRLS_TX_CHKSUM_EN inserts two hex checksum digits,
// HEX((chan + value) mod 256), before the LF. That gives a 7-byte frame.
// Line handshake: there is no ready/valid pair. A channel is "offered"
// whenever its input differs from its shadow copy or its force bit is set.
// It is "accepted" on the clock edge where the IDLE state selects it.
module a_ctrls_tx #(
    parameter int fCLK  = 50_000_000,
    parameter int fBAUD = 9_600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] blend,
    input  logic [7:0] gain,
    input  logic [7:0] a8,
    input  logic [7:0] a5,
    input  logic [7:0] a4,
    input  logic [7:0] delay,
    input  logic [7:0] feedbk,
    input  logic       force_all,
    output logic       CTRL_TX,
    output logic       busy,
    output logic       frame_done
);

    localparam int BIT_CYC = fCLK / fBAUD;
    localparam int CW      = $clog2(BIT_CYC);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYC - 1);
`ifdef A_CTRLS_TX_CHKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd6;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [2:0]    chan_q, chan_d;
    logic [7:0]    val_q, val_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [6:0]    force_q, force_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [7:0]    shadow_q [7];
    logic [7:0]    shadow_d [7];

    logic [7:0]    in_vals [7];
    logic [6:0]    pending;
    logic          sel_found;
    logic [2:0]    sel_idx;
    logic [7:0]    cur_byte;

    function automatic logic [2:0] add_mod7(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd7) s = s - 4'd7;
        return s[2:0];
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign in_vals[0] = blend;
    assign in_vals[1] = gain;
    assign in_vals[2] = a8;
    assign in_vals[3] = a5;
    assign in_vals[4] = a4;
    assign in_vals[5] = delay;
    assign in_vals[6] = feedbk;

    // A channel is pending when its value moved away from the last sent copy or a resend is queued
    always_comb begin
        pending = '0;
        for (int i = 0; i < 7; i++) begin
            pending[i] = (in_vals[i] != shadow_q[i]) || force_q[i];
        end
    end

    // Round-robin pick: first pending channel scanning upward from the pointer, mod 7
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (!sel_found && pending[add_mod7(ptr_q, 3'(k))]) begin
                sel_found = 1'b1;
                sel_idx   = add_mod7(ptr_q, 3'(k));
            end
        end
    end

    // Byte currently being shifted, chosen by its position in the frame
    always_comb begin
`ifdef A_CTRLS_TX_CHKSUM_EN
        logic [7:0] chk;
        chk = {5'd0, chan_q} + val_q;
`endif
        cur_byte = 8'h0A;
        case (byte_q)
            3'd0:    cur_byte = 8'h3A;
            3'd1:    cur_byte = 8'h30 + {5'd0, chan_q};
            3'd2:    cur_byte = hex_char(val_q[7:4]);
            3'd3:    cur_byte = hex_char(val_q[3:0]);
`ifdef A_CTRLS_TX_CHKSUM_EN
            3'd4:    cur_byte = hex_char(chk[7:4]);
            3'd5:    cur_byte = hex_char(chk[3:0]);
`endif
            default: cur_byte = 8'h0A;
        endcase
    end

    // Next-state logic: channel selection, bit timing, and byte sequencing
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        chan_d   = chan_q;
        val_d    = val_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        force_d  = force_q;
        ptr_d    = ptr_q;
        shadow_d = shadow_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (sel_found) begin
                    chan_d            = sel_idx;
                    val_d             = in_vals[sel_idx];
                    shadow_d[sel_idx] = in_vals[sel_idx];
                    force_d[sel_idx]  = 1'b0;
                    ptr_d             = add_mod7(sel_idx, 3'd1);
                    byte_d            = 3'd0;
                    baud_d            = '0;
                    busy_d            = 1'b1;
                    tx_d              = 1'b0;
                    state_d           = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_d];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // A resend request overrides the clear of the channel being selected this edge
        if (force_all) force_d = 7'h7F;
    end

    // State registers; reset drops the line high immediately and forgets all history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            chan_q  <= 3'd0;
            val_q   <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            force_q <= 7'h00;
            ptr_q   <= 3'd0;
            for (int i = 0; i < 7; i++) shadow_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            chan_q   <= chan_d;
            val_q    <= val_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            force_q  <= force_d;
            ptr_q    <= ptr_d;
            shadow_q <= shadow_d;
        end
    end

    assign CTRL_TX    = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_a_ctrls_tx.sv
// Directed testbench for a_ctrls_tx with fCLK=16, fBAUD=1 (16 clocks per bit).
// Outputs are sampled on the falling clock edge. Inputs are driven there too.
module tb_a_ctrls_tx;

    localparam int BIT_CYC = 16;
`ifdef A_CTRLS_TX_CHKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 5;
`endif
    localparam int BYTE_CYC  = 10 * BIT_CYC;
    localparam int FRAME_CYC = NB * BYTE_CYC;

    logic       clk;
    logic       reset_n;
    logic [7:0] blend, gain, a8, a5, a4, delay, feedbk;
    logic       force_all;
    logic       CTRL_TX, busy, frame_done;

    int         n_checks;
    int         n_fail;
    logic [7:0] exp_b [7];
    logic       obs_tx [FRAME_CYC];

    a_ctrls_tx #(.fCLK(16), .fBAUD(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .blend      (blend),
        .gain       (gain),
        .a8         (a8),
        .a5         (a5),
        .a4         (a4),
        .delay      (delay),
        .feedbk     (feedbk),
        .force_all  (force_all),
        .CTRL_TX    (CTRL_TX),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        reset_n   = 1'b0;
        force_all = 1'b0;
        blend = 8'h00; gain = 8'h00; a8 = 8'h00; a5 = 8'h00;
        a4 = 8'h00; delay = 8'h00; feedbk = 8'h00;
    end

    // ---------------- driver / checker tasks ----------------

    task automatic apply_reset();
        reset_n   = 1'b0;
        force_all = 1'b0;
        blend = 8'h00; gain = 8'h00; a8 = 8'h00; a5 = 8'h00;
        a4 = 8'h00; delay = 8'h00; feedbk = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (CTRL_TX !== 1'b1) begin n_fail++; $display("FAIL reset CTRL_TX: got %b want 1", CTRL_TX); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
        reset_n = 1'b1;
    endtask

    // Expected frame: ':' c h l [k1 k2] LF
    task automatic set_exp(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                           input logic [7:0] k1, input logic [7:0] k2);
        exp_b[0] = 8'h3A;
        exp_b[1] = c;
        exp_b[2] = h;
        exp_b[3] = l;
`ifdef A_CTRLS_TX_CHKSUM_EN
        exp_b[4] = k1;
        exp_b[5] = k2;
        exp_b[6] = 8'h0A;
`else
        exp_b[4] = 8'h0A;
        exp_b[5] = k1;
        exp_b[6] = k2;
`endif
    endtask

    // Wait for the start bit, capture one full frame and check it bit by bit.
    // The call ends on the falling edge just after the last stop bit.
    task automatic rx_frame(input string name, input int exp_gap);
        int       gap;
        int       busy_bad;
        int       done_bad;
        int       wave_bad;
        int       first_bad;
        int       b;
        int       j;
        logic     e;
        logic [9:0] got;
        logic [9:0] want;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (CTRL_TX !== 1'b0 && gap < 3000);
        n_checks++;
        if (CTRL_TX !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: no start bit within %0d clocks", name, gap);
            return;
        end
        n_checks++;
        if (gap != exp_gap) begin
            n_fail++;
            $display("FAIL %s gap: start bit after %0d clocks, want %0d", name, gap, exp_gap);
        end
        busy_bad = 0;
        done_bad = 0;
        for (int n = 0; n < FRAME_CYC; n++) begin
            obs_tx[n] = CTRL_TX;
            if (busy !== 1'b1) busy_bad++;
            if (frame_done !== 1'b0) done_bad++;
            @(negedge clk);
        end
        for (int bi = 0; bi < NB; bi++) begin
            for (int jj = 0; jj < 10; jj++) got[jj] = obs_tx[bi * BYTE_CYC + jj * BIT_CYC + BIT_CYC / 2];
            want = {1'b1, exp_b[bi], 1'b0};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s byte%0d: got data %h (start %b stop %b) want %h",
                         name, bi, got[8:1], got[0], got[9], exp_b[bi]);
            end
        end
        wave_bad  = 0;
        first_bad = -1;
        for (int n = 0; n < FRAME_CYC; n++) begin
            b = n / BYTE_CYC;
            j = (n % BYTE_CYC) / BIT_CYC;
            if (j == 0)      e = 1'b0;
            else if (j == 9) e = 1'b1;
            else             e = exp_b[b][j-1];
            if (obs_tx[n] !== e) begin
                wave_bad++;
                if (first_bad < 0) first_bad = n;
            end
        end
        n_checks++;
        if (wave_bad != 0) begin
            n_fail++;
            $display("FAIL %s bit timing: %0d wrong clocks, first at clock %0d, want 0 wrong", name, wave_bad, first_bad);
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL %s busy: low on %0d clocks inside frame, want 0", name, busy_bad);
        end
        n_checks++;
        if (done_bad != 0) begin
            n_fail++;
            $display("FAIL %s early done: frame_done high on %0d clocks inside frame, want 0", name, done_bad);
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame_done: got %b after last stop bit, want 1", name, frame_done);
        end
        n_checks++;
        if (busy !== 1'b0 || CTRL_TX !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end idle: got busy=%b line=%b, want busy=0 line=1", name, busy, CTRL_TX);
        end
    endtask

    task automatic expect_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (CTRL_TX !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s idle: %0d clocks not idle out of %0d, want 0", name, bad, cycles);
        end
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        apply_reset();
        expect_idle("quiet", 2000);
    endtask

    task automatic test_single();
        apply_reset();
        gain = 8'h3C;
        set_exp("1", "3", "C", "3", "D");
        rx_frame("single", 1);
        expect_idle("single", 100);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        blend  = 8'hA5;
        feedbk = 8'h01;
        set_exp("0", "A", "5", "A", "5");
        rx_frame("b2b ch0", 1);
        set_exp("6", "0", "1", "0", "7");
        rx_frame("b2b ch6", 1);
        expect_idle("b2b", 100);
    endtask

    task automatic test_force_all();
        logic [7:0] c;
        apply_reset();
        force_all = 1'b1;
        @(negedge clk);
        force_all = 1'b0;
        for (int i = 0; i < 7; i++) begin
            c = 8'h30 + 8'(i);
            set_exp(c, "0", "0", "0", c);
            rx_frame("force", 1);
        end
        expect_idle("force", 200);
    endtask

    // force_all on the same edge that selects channel 1: channel 1 must be resent last
    task automatic test_force_collide();
        logic [7:0] c;
        int         ch;
        apply_reset();
        gain      = 8'h3C;
        force_all = 1'b1;
        set_exp("1", "3", "C", "3", "D");
        fork
            rx_frame("collide ch1", 1);
            begin
                @(negedge clk);
                force_all = 1'b0;
            end
        join
        for (int k = 0; k < 6; k++) begin
            ch = (k + 2) % 7;
            c  = 8'h30 + 8'(ch);
            set_exp(c, "0", "0", "0", c);
            rx_frame("collide zero", 1);
        end
        set_exp("1", "3", "C", "3", "D");
        rx_frame("collide resend", 1);
        expect_idle("collide", 200);
    endtask

    task automatic test_change_mid();
        apply_reset();
        gain = 8'h3C;
        set_exp("1", "3", "C", "3", "D");
        fork
            rx_frame("mid old", 1);
            begin
                repeat (400) @(negedge clk);
                gain = 8'h3D;
            end
        join
        set_exp("1", "3", "D", "3", "E");
        rx_frame("mid new", 1);
        expect_idle("mid", 200);
    endtask

    task automatic test_reset_mid();
        int w;
        apply_reset();
        delay = 8'h80;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (CTRL_TX !== 1'b0 && w < 100);
        n_checks++;
        if (CTRL_TX !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid start: no start bit within %0d clocks", w);
        end
        repeat (BYTE_CYC + BIT_CYC / 2) @(negedge clk);
        n_checks++;
        if (CTRL_TX !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid byte1 start bit: got %b want 0", CTRL_TX);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (CTRL_TX !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid async: got line=%b busy=%b, want line=1 busy=0", CTRL_TX, busy);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        set_exp("5", "8", "0", "8", "5");
        rx_frame("rstmid resend", 1);
        expect_idle("rstmid", 200);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_force_all();
        test_force_collide();
        test_change_mid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
